// File: rtl/spi_slave_param.sv
// spi_slave_param: parametrised SPI slave front end between an SPI master and
// the single-port RAM rx/tx handshake. One MOSI bit per rising clk edge while
// SS_n is low; read data is returned MSB first on MISO.
module spi_slave_param #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TX_WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned         BIT_CW      = $clog2(DATA_W + 2);
  localparam int unsigned         WAIT_CW     = $clog2(TX_WAIT_MAX + 1);
  localparam logic [BIT_CW-1:0]   LAST_RX_BIT = BIT_CW'(DATA_W);
  localparam logic [BIT_CW-1:0]   LAST_TX_BIT = BIT_CW'(DATA_W - 1);
  localparam logic [WAIT_CW-1:0]  WAIT_LAST   = WAIT_CW'(TX_WAIT_MAX - 1);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SHIFT_OUT, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W+1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                miso_q, miso_d;
  logic                rd_pending_q, rd_pending_d;
  logic                complete_q, complete_d;
  logic [BIT_CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WAIT_CW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
  logic [DATA_W+1:0]   rx_shift;
  logic                frame_ok;

  assign rx_shift  = {rx_data_q[DATA_W:0], MOSI};
  assign MISO      = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

  // Next-state, frame capture, consistency check and read-back sequencing.
  always_comb begin
    state_d      = state_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    miso_d       = 1'b0;
    rd_pending_d = rd_pending_q;
    complete_d   = complete_q;
    bit_cnt_d    = bit_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    tx_shift_d   = tx_shift_q;
    // Second opcode bit: free in WRITE, 0 for READ_ADD, 1 for READ_DATA.
    frame_ok     = (state_q == WRITE) || (rx_shift[DATA_W] == (state_q == READ_DATA));

    case (state_q)
      IDLE: begin
        if (!SS_n) begin
          state_d    = CHK_CMD;
          bit_cnt_d  = '0;
          complete_d = 1'b0;
        end
      end
      CHK_CMD: begin
        if (SS_n) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else begin
          rx_data_d = {{(DATA_W+1){1'b0}}, MOSI};
          if (!MOSI)             state_d = WRITE;
          else if (!rd_pending_q) state_d = READ_ADD;
          else                   state_d = READ_DATA;
        end
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n) begin
          state_d     = IDLE;
          frame_err_d = !complete_q;
        end else if (!complete_q) begin
          rx_data_d = rx_shift;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_RX_BIT) begin
            // Frame finished: completed or rejected frames both freeze here.
            complete_d = 1'b1;
            if (frame_ok) begin
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD) rd_pending_d = 1'b1;
              if (state_q == READ_DATA) begin
                state_d    = WAIT_TX;
                wait_cnt_d = '0;
              end
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end
      end
      WAIT_TX: begin
        if (SS_n) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (tx_valid) begin
          tx_shift_d = tx_data << 1;
          miso_d     = tx_data[DATA_W-1];
          bit_cnt_d  = '0;
          state_d    = SHIFT_OUT;
        end else if (wait_cnt_q == WAIT_LAST) begin
          frame_err_d = 1'b1;
          state_d     = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      SHIFT_OUT: begin
        if (SS_n) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (bit_cnt_q == LAST_TX_BIT) begin
          rd_pending_d = 1'b0;
          state_d      = DONE;
        end else begin
          miso_d     = tx_shift_q[DATA_W-1];
          tx_shift_d = tx_shift_q << 1;
          bit_cnt_d  = bit_cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (SS_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      miso_q       <= 1'b0;
      rd_pending_q <= 1'b0;
      complete_q   <= 1'b0;
      bit_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      tx_shift_q   <= '0;
    end else begin
      state_q      <= state_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      miso_q       <= miso_d;
      rd_pending_q <= rd_pending_d;
      complete_q   <= complete_d;
      bit_cnt_q    <= bit_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      tx_shift_q   <= tx_shift_d;
    end
  end

endmodule
